pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Sequencer that owns the fetch program counter for a fixed-width RISC front end and issues fetch addresses to the instruction memory over a valid/ready handshake.
It arbitrates between boot, sequential advance, branch redirect, trap vectoring and debug halt/resume.
It tags each issued fetch with an epoch so downstream logic can squash stale responses.
It sits between the execute/trap logic and the I-fetch port.

Parameters:
ADDR_WIDTH, 32, byte-address width.
INSN_SIZE, 4, instruction size in bytes (1, 2, 4, 8 or 16).
ADDR_OFS, derived (local): log2(INSN_SIZE), which is 0/1/2/3/4; all addresses are word addresses [ADDR_WIDTH-1:ADDR_OFS].
EPOCH_WIDTH, 2, width of the fetch epoch tag.
CNT_WIDTH, 32, width of the accepted-fetch counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk externally.
rst_addr  in  ADDR_WIDTH-ADDR_OFS  boot word address, sampled on first edge after reset release.
redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
redirect_addr  in  ADDR_WIDTH-ADDR_OFS  redirect target.
trap_valid  in  1  trap/interrupt request, single-cycle pulse.
trap_vec  in  ADDR_WIDTH-ADDR_OFS  trap vector target.
halt_req  in  1  debug halt request, level.
resume_req  in  1  debug resume request, pulse.
fetch_ready  in  1  I-fetch port accepts fetch_addr this cycle.
fetch_valid  out  1  fetch_addr valid.
fetch_addr  out  ADDR_WIDTH-ADDR_OFS  current fetch word address.
fetch_epoch  out  EPOCH_WIDTH  epoch tag of the current fetch.
halted  out  1  1 while in HALT.
fetch_cnt  out  CNT_WIDTH  number of accepted fetches (fetch_valid & fetch_ready), wraps.

Behaviour:
- States: BOOT, RUN, HALT. All outputs are registered.
- Reset (rst=0, async): state=BOOT, fetch_valid=0, fetch_addr=0, fetch_epoch=0, halted=0, fetch_cnt=0. Reset mid-operation discards everything immediately.
- BOOT, first posedge with rst=1: fetch_addr<=rst_addr, fetch_valid<=1, state<=RUN. Other inputs are ignored this edge. Result: fetch_valid=1 one cycle after reset release.
- Accept = fetch_valid & fetch_ready. On accept, fetch_cnt<=fetch_cnt+1, modulo 2^CNT_WIDTH.
- RUN priority per edge, highest first:
  1. trap_valid: fetch_addr<=trap_vec, epoch+1, fetch_valid=1. Any unaccepted address is dropped.
  2. redirect_valid: fetch_addr<=redirect_addr, epoch+1, fetch_valid=1.
  3. halt_req: if accept or !fetch_valid, state<=HALT, fetch_valid<=0, fetch_addr<=next sequential address (addr+1 if accepted, else unchanged). Otherwise wait for accept.
  4. Accept: fetch_addr<=fetch_addr+1. Wraps modulo 2^(ADDR_WIDTH-ADDR_OFS); the all-ones address wraps to 0.
  5. No accept: hold fetch_addr and fetch_epoch stable (AXI-style: no change while valid & !ready, except on trap/redirect).
- A trap or redirect coinciding with an accept still counts the accept. The new address replaces fetch_addr+1.
- Epoch increments wrap modulo 2^EPOCH_WIDTH. The epoch changes only on trap/redirect.
- HALT: halted=1, fetch_valid=0.
  - trap_valid: fetch_addr<=trap_vec, epoch+1, state<=RUN, fetch_valid<=1 (trap wakes the core).
  - redirect_valid: fetch_addr<=redirect_addr, epoch+1, remain HALT.
  - resume_req & !halt_req: state<=RUN, fetch_valid<=1 at the held fetch_addr, epoch unchanged.
  - resume_req & halt_req together: remain HALT.
- halted deasserts on the same edge fetch_valid reasserts.
- Latency: request to new fetch_addr visible on the output is 1 cycle.

Test Plan:
- Boot (ADDR_WIDTH=32, INSN_SIZE=4): hold rst=0 for 3 cycles, rst_addr=30'h100, release, fetch_ready=1. Expect fetch_valid=0 during reset, then 30'h100, 30'h101, 30'h102 on consecutive cycles, and fetch_cnt=3 after the third accept.
- Backpressure: at fetch_addr=30'h104, drop fetch_ready for 4 cycles. Expect fetch_addr held at 30'h104, epoch constant, fetch_cnt frozen; on ready, 30'h105 follows.
- Priority/epoch: at 30'h108 with ready=0, pulse trap_valid (vec 30'h40) and redirect_valid (30'h200) together. Expect next fetch_addr=30'h40, epoch 0->1, and 30'h108 never accepted. Four further redirects wrap the epoch 1->2->3->0->1.
- Halt/resume: assert halt_req at 30'h300 with ready=0, then ready=1. Expect one accept of 30'h300, then halted=1, fetch_valid=0. A redirect to 30'h500 in HALT keeps halted=1 and increments epoch. Pulsing resume_req after halt_req drops gives fetch_valid=1 at 30'h500.
- Wrap/trap wake: fetch at 30'h3FFF_FFFF accepted -> next 30'h0. In HALT, trap_valid (vec 30'h10) -> RUN, fetch_addr=30'h10, halted=0.
- Reset mid-run: pull rst low asynchronously between edges while fetch_valid=1. Expect outputs to clear before the next edge, and after release the boot sequence restarts at rst_addr.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Owns the fetch program counter of the front end. Issues word-addressed
// fetch requests to the instruction memory over a valid/ready handshake and
// picks the next address from boot, sequential advance, branch redirect,
// trap vectoring or debug halt/resume. Every trap or redirect bumps an
// epoch tag that travels with each fetch, so downstream logic can squash
// responses that belong to an abandoned path.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   rst_addr       boot word address, taken on the first edge out of reset
//   redirect_valid branch/jump redirect pulse, target in redirect_addr
//   trap_valid     trap/interrupt pulse, target in trap_vec
//   halt_req       debug halt request (level)
//   resume_req     debug resume request (pulse)
//   fetch_ready    I-fetch port accepts fetch_addr this cycle
//   fetch_valid    fetch_addr is a live request
//   fetch_addr     current fetch word address
//   fetch_epoch    epoch tag of the current fetch
//   halted         high while the sequencer is parked in HALT
//   fetch_cnt      running count of accepted fetches (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSN_SIZE   = 4,
  parameter int EPOCH_WIDTH = 2,
  parameter int CNT_WIDTH   = 32,
  localparam int ADDR_OFS   = $clog2(INSN_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-ADDR_OFS-1:0] rst_addr,
  input  logic                           redirect_valid,
  input  logic [ADDR_WIDTH-ADDR_OFS-1:0] redirect_addr,
  input  logic                           trap_valid,
  input  logic [ADDR_WIDTH-ADDR_OFS-1:0] trap_vec,
  input  logic                           halt_req,
  input  logic                           resume_req,
  input  logic                           fetch_ready,
  output logic                           fetch_valid,
  output logic [ADDR_WIDTH-ADDR_OFS-1:0] fetch_addr,
  output logic [EPOCH_WIDTH-1:0]         fetch_epoch,
  output logic                           halted,
  output logic [CNT_WIDTH-1:0]           fetch_cnt
);

  localparam int AW = ADDR_WIDTH - ADDR_OFS;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic                   halted_q, halted_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   accept;
  logic [AW-1:0]          addrNext;
  logic [EPOCH_WIDTH-1:0] epochNext;

  assign accept    = valid_q & fetch_ready;
  assign addrNext  = addr_q + AW'(1);
  assign epochNext = epoch_q + EPOCH_WIDTH'(1);

  // Next-state selection. The accept counter is independent of the state
  // decision, so an accept that coincides with a trap or redirect is still
  // counted even though its +1 address is replaced by the new target.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    epoch_d  = epoch_q;
    halted_d = halted_q;
    cnt_d    = cnt_q + CNT_WIDTH'(accept);

    unique case (state_q)
      BOOT: begin
        addr_d   = rst_addr;
        valid_d  = 1'b1;
        halted_d = 1'b0;
        state_d  = RUN;
      end

      RUN: begin
        if (trap_valid) begin
          addr_d  = trap_vec;
          epoch_d = epochNext;
          valid_d = 1'b1;
        end else if (redirect_valid) begin
          addr_d  = redirect_addr;
          epoch_d = epochNext;
          valid_d = 1'b1;
        end else if (halt_req) begin
          // A pending request must be accepted before parking, so the
          // handshake never sees valid withdrawn while ready is low.
          if (accept || !valid_q) begin
            state_d  = HALT;
            valid_d  = 1'b0;
            halted_d = 1'b1;
            addr_d   = accept ? addrNext : addr_q;
          end
        end else if (accept) begin
          addr_d = addrNext;
        end
      end

      HALT: begin
        valid_d = 1'b0;
        if (trap_valid) begin
          addr_d   = trap_vec;
          epoch_d  = epochNext;
          state_d  = RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end else if (redirect_valid) begin
          addr_d  = redirect_addr;
          epoch_d = epochNext;
        end else if (resume_req && !halt_req) begin
          state_d  = RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end

      default: begin
        state_d  = BOOT;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  // All state and outputs are registered together; reset drops any
  // in-flight request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      epoch_q  <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      epoch_q  <= epoch_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_addr  = addr_q;
  assign fetch_epoch = epoch_q;
  assign halted      = halted_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed bench for pc_fetch_ctrl at ADDR_WIDTH=32, INSN_SIZE=4 (30-bit
// word addresses). Inputs change on the falling edge and outputs are
// sampled on the falling edge, half a cycle after the register update.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [29:0] rstAddr;
  logic        redirectValid;
  logic [29:0] redirectAddr;
  logic        trapValid;
  logic [29:0] trapVec;
  logic        haltReq;
  logic        resumeReq;
  logic        fetchReady;
  logic        fetchValid;
  logic [29:0] fetchAddr;
  logic [1:0]  fetchEpoch;
  logic        halted;
  logic [31:0] fetchCnt;

  int checkCount = 0;
  int failCount  = 0;

  pc_fetch_ctrl #(
    .ADDR_WIDTH (32),
    .INSN_SIZE  (4),
    .EPOCH_WIDTH(2),
    .CNT_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rst_addr      (rstAddr),
    .redirect_valid(redirectValid),
    .redirect_addr (redirectAddr),
    .trap_valid    (trapValid),
    .trap_vec      (trapVec),
    .halt_req      (haltReq),
    .resume_req    (resumeReq),
    .fetch_ready   (fetchReady),
    .fetch_valid   (fetchValid),
    .fetch_addr    (fetchAddr),
    .fetch_epoch   (fetchEpoch),
    .halted        (halted),
    .fetch_cnt     (fetchCnt)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends on its own
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, observed, expected);
    end
  endtask

  // Checks the full visible output set against hand-computed values
  task automatic expectState(input string tag, input logic valid,
                             input logic [29:0] addr, input logic [1:0] epoch,
                             input logic [31:0] cnt, input logic halt);
    checkOutput({tag, ".valid"},  64'(fetchValid), 64'(valid));
    checkOutput({tag, ".addr"},   64'(fetchAddr),  64'(addr));
    checkOutput({tag, ".epoch"},  64'(fetchEpoch), 64'(epoch));
    checkOutput({tag, ".cnt"},    64'(fetchCnt),   64'(cnt));
    checkOutput({tag, ".halted"}, 64'(halted),     64'(halt));
  endtask

  // Drives one cycle of control inputs, then waits for the result
  task automatic applyStimulus(input logic trapV, input logic redirV,
                               input logic haltV, input logic resumeV,
                               input logic readyV);
    trapValid     = trapV;
    redirectValid = redirV;
    haltReq       = haltV;
    resumeReq     = resumeV;
    fetchReady    = readyV;
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b0;
    rstAddr       = 30'h100;
    redirectValid = 1'b0;
    redirectAddr  = '0;
    trapValid     = 1'b0;
    trapVec       = '0;
    haltReq       = 1'b0;
    resumeReq     = 1'b0;
    fetchReady    = 1'b1;

    // Boot sequence
    repeat (3) @(negedge clk);
    expectState("reset", 1'b0, 30'h0, 2'd0, 32'd0, 1'b0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    expectState("boot", 1'b1, 30'h100, 2'd0, 32'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("seq1.addr", 64'(fetchAddr), 64'h101);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("seq2.addr", 64'(fetchAddr), 64'h102);
    applyStimulus(0, 0, 0, 0, 1);
    expectState("seq3", 1'b1, 30'h103, 2'd0, 32'd3, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("seq4.addr", 64'(fetchAddr), 64'h104);

    // Backpressure holds address, epoch and count
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      expectState($sformatf("stall%0d", i), 1'b1, 30'h104, 2'd0, 32'd4, 1'b0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    expectState("unstall", 1'b1, 30'h105, 2'd0, 32'd5, 1'b0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    expectState("at108", 1'b1, 30'h108, 2'd0, 32'd8, 1'b0);

    // Trap beats a simultaneous redirect; stalled 0x108 is never accepted
    trapVec      = 30'h40;
    redirectAddr = 30'h200;
    applyStimulus(1, 1, 0, 0, 0);
    expectState("trapPrio", 1'b1, 30'h40, 2'd1, 32'd8, 1'b0);

    // Epoch wrap through four redirects
    redirectAddr = 30'h200;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("redir1.epoch", 64'(fetchEpoch), 64'd2);
    redirectAddr = 30'h201;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("redir2.epoch", 64'(fetchEpoch), 64'd3);
    redirectAddr = 30'h202;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("redir3.epoch", 64'(fetchEpoch), 64'd0);
    redirectAddr = 30'h300;
    applyStimulus(0, 1, 0, 0, 0);
    expectState("redir4", 1'b1, 30'h300, 2'd1, 32'd8, 1'b0);

    // Halt waits for the pending fetch to be accepted
    applyStimulus(0, 0, 1, 0, 0);
    expectState("haltWait", 1'b1, 30'h300, 2'd1, 32'd8, 1'b0);
    applyStimulus(0, 0, 1, 0, 1);
    expectState("halted", 1'b0, 30'h301, 2'd1, 32'd9, 1'b1);
    redirectAddr = 30'h500;
    applyStimulus(0, 1, 1, 0, 1);
    expectState("haltRedir", 1'b0, 30'h500, 2'd2, 32'd9, 1'b1);
    applyStimulus(0, 0, 1, 1, 1);
    expectState("resumeBlocked", 1'b0, 30'h500, 2'd2, 32'd9, 1'b1);
    applyStimulus(0, 0, 0, 1, 1);
    expectState("resumed", 1'b1, 30'h500, 2'd2, 32'd9, 1'b0);

    // Address wrap at the top of the word space
    redirectAddr = 30'h3FFF_FFFF;
    applyStimulus(0, 1, 0, 0, 1);
    expectState("toTop", 1'b1, 30'h3FFF_FFFF, 2'd3, 32'd10, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    expectState("wrap", 1'b1, 30'h0, 2'd3, 32'd11, 1'b0);

    // Trap wakes the core out of HALT
    applyStimulus(0, 0, 1, 0, 1);
    expectState("halt2", 1'b0, 30'h1, 2'd3, 32'd12, 1'b1);
    trapVec = 30'h10;
    applyStimulus(1, 0, 0, 0, 1);
    expectState("trapWake", 1'b1, 30'h10, 2'd0, 32'd12, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    expectState("afterWake", 1'b1, 30'h11, 2'd0, 32'd13, 1'b0);

    // Asynchronous reset between edges, then reboot
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    expectState("asyncRst", 1'b0, 30'h0, 2'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    expectState("reboot", 1'b1, 30'h100, 2'd0, 32'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    expectState("reboot1", 1'b1, 30'h101, 2'd0, 32'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
